// File: rtl/scd_mem_pkg.sv
// Shared types and helpers for the wait-state memory: controller states,
// channel identifiers, byte-lane merge and byte-address to word-index mapping.
package scd_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {CH_CPU, CH_DBG} chan_t;

  // Helpers work on the widest supported word; callers cast in and out.
  localparam int MAX_DATA_W = 128;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] w;
    w = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) w[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] word_index(
    input logic [31:0] addr,
    input int unsigned shift
  );
    return addr >> shift;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read port returns the post-write word, so a write responds with merged data.
module mem_array
  import scd_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (we && be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= DATA_W'(byte_merge(MAX_DATA_W'(mem[idx]), MAX_DATA_W'(wdata),
                                  MAX_BE_W'(we ? be : '0)));
    end
  end

endmodule

// File: rtl/wait_state_memory.sv
// Two-channel (cpu, dbg) word memory with byte addressing, byte enables and a
// configurable number of wait states between acceptance and response.
module wait_state_memory
  import scd_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_err,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W/8-1:0] dbg_be,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_ready,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SHIFT = $clog2(BE_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: req is a level held until the one-cycle ready strobe; the
  // requester drops req in the ready cycle, since req seen in IDLE is new.
  state_t            state, state_n;
  logic [3:0]        count_q, count_n;
  logic              mem_en;
  logic              accept;

  chan_t             sel_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [31:0]       sel_widx;

  chan_t             gnt_q;
  logic              we_q;
  logic              oor_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] arr_rdata, resp_data;
  logic [DATA_W-1:0] cpu_hold, dbg_hold;

  // dbg wins whenever both channels are requesting in IDLE.
  assign sel_gnt   = dbg_req ? CH_DBG : CH_CPU;
  assign sel_we    = dbg_req ? dbg_we    : cpu_we;
  assign sel_addr  = dbg_req ? dbg_addr  : cpu_addr;
  assign sel_be    = dbg_req ? dbg_be    : cpu_be;
  assign sel_wdata = dbg_req ? dbg_wdata : cpu_wdata;
  assign sel_widx  = word_index(32'(sel_addr), SHIFT);
  assign accept    = (state == IDLE) && (cpu_req || dbg_req);

  always_comb begin
    state_n = state;
    count_n = count_q;
    mem_en  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_n = WAIT;
          count_n = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (count_q == 4'd0) begin
          state_n = RESP;
          mem_en  = !oor_q;
        end else begin
          count_n = count_q - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      gnt_q    <= CH_CPU;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      cpu_hold <= '0;
      dbg_hold <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      if (accept) begin
        gnt_q   <= sel_gnt;
        we_q    <= sel_we;
        oor_q   <= (sel_widx >= 32'(DEPTH));
        idx_q   <= sel_widx[IDX_W-1:0];
        be_q    <= sel_be;
        wdata_q <= sel_wdata;
      end
      if (cpu_ready) cpu_hold <= resp_data;
      if (dbg_ready) dbg_hold <= resp_data;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (we_q),
    .idx   (idx_q),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Out-of-range accesses never touch the array and answer with zero data.
  assign resp_data = oor_q ? '0 : arr_rdata;

  assign cpu_ready = (state == RESP) && (gnt_q == CH_CPU);
  assign dbg_ready = (state == RESP) && (gnt_q == CH_DBG);
  assign cpu_err   = cpu_ready && oor_q;
  assign dbg_err   = dbg_ready && oor_q;
  assign cpu_rdata = cpu_ready ? resp_data : cpu_hold;
  assign dbg_rdata = dbg_ready ? resp_data : dbg_hold;

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: three instances (WS=2/D=128, WS=0/D=64,
// WS=3/D=128), directed vector table, hand sequences and a random model run.
module tb_wait_state_memory;

  logic        clk = 1'b0;
  logic [2:0]  rst_n, cpu_req, dbg_req;
  logic [2:0]  cpu_ready, dbg_ready, cpu_err, dbg_err;
  logic [15:0] cpu_rdata [3];
  logic [15:0] dbg_rdata [3];
  logic        cpu_we, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [1:0]  cpu_be, dbg_be;
  logic [15:0] cpu_wdata, dbg_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap_cnt = 0;

  logic [15:0] mem_m [3][128];
  logic [15:0] last_cpu [3];
  logic [15:0] last_dbg [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 2 : (g == 1) ? 0 : 3;
    localparam int DP = (g == 1) ? 64 : 128;
    wait_state_memory #(
      .DATA_W(16), .ADDR_W(8), .DEPTH(DP), .WAIT_STATES(WS)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_be    (cpu_be),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready[g]),
      .cpu_rdata (cpu_rdata[g]),
      .cpu_err   (cpu_err[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_be    (dbg_be),
      .dbg_wdata (dbg_wdata),
      .dbg_ready (dbg_ready[g]),
      .dbg_rdata (dbg_rdata[g]),
      .dbg_err   (dbg_err[g])
    );
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cpu_ready[k] && dbg_ready[k]) overlap_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 0 : 3;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 1) ? 64 : 128;
  endfunction

  // Reference: word array per instance, masks built from byte enables.
  function automatic void model_access(input int k, input bit we, input logic [7:0] addr,
                                       input logic [1:0] be, input logic [15:0] wdata,
                                       output logic [15:0] rdata, output logic err);
    int idx;
    logic [15:0] mask;
    idx  = int'(addr) / 2;
    mask = {{8{be[1]}}, {8{be[0]}}};
    if (idx >= depth_of(k)) begin
      rdata = 16'h0;
      err   = 1'b1;
    end else begin
      err = 1'b0;
      if (we) mem_m[k][idx] = (mem_m[k][idx] & ~mask) | (wdata & mask);
      rdata = mem_m[k][idx];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_txn(input int k, input bit dbg, input bit we, input logic [7:0] addr,
                        input logic [1:0] be, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic err, output int lat);
    bit seen;
    @(negedge clk);
    if (dbg) begin
      dbg_we = we; dbg_addr = addr; dbg_be = be; dbg_wdata = wdata; dbg_req[k] = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata; cpu_req[k] = 1'b1;
    end
    @(posedge clk); #1;
    // Inputs other than req must be ignored after the accepting edge.
    if (dbg) begin
      dbg_we = ~we; dbg_addr = ~addr; dbg_be = ~be; dbg_wdata = ~wdata;
    end else begin
      cpu_we = ~we; cpu_addr = ~addr; cpu_be = ~be; cpu_wdata = ~wdata;
    end
    lat = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dbg ? dbg_ready[k] : cpu_ready[k]) begin
        seen  = 1'b1;
        rdata = dbg ? dbg_rdata[k] : cpu_rdata[k];
        err   = dbg ? dbg_err[k] : cpu_err[k];
        check($sformatf("hold_other_k%0d", k), 32'(dbg ? cpu_rdata[k] : dbg_rdata[k]),
              32'(dbg ? last_cpu[k] : last_dbg[k]));
      end
    end
    if (dbg) dbg_req[k] = 1'b0; else cpu_req[k] = 1'b0;
    if (!seen) check($sformatf("timeout_k%0d", k), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string name, input int k, input bit dbg, input bit we,
                           input logic [7:0] addr, input logic [1:0] be, input logic [15:0] wdata,
                           input logic [15:0] exp_rdata, input logic exp_err);
    logic [15:0] rd;
    logic er;
    int lat;
    do_txn(k, dbg, we, addr, be, wdata, rd, er, lat);
    check({name, "_rdata"}, 32'(rd), 32'(exp_rdata));
    check({name, "_err"}, 32'(er), 32'(exp_err));
    check({name, "_lat"}, 32'(lat), 32'(ws_of(k) + 1));
    if (dbg) last_dbg[k] = exp_rdata; else last_cpu[k] = exp_rdata;
  endtask

  typedef struct {
    int          k;
    bit          dbg;
    bit          we;
    logic [7:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [15:0] mr, exp_d, exp_c, d;
    logic me;
    int t_d, t_c, prev;
    bit seen;

    rst_n = '0; cpu_req = '0; dbg_req = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_be = '0; dbg_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      last_cpu[k] = '0;
      last_dbg[k] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_cpu_ready_k%0d", k), 32'(cpu_ready[k]), 32'd0);
      check($sformatf("rst_dbg_ready_k%0d", k), 32'(dbg_ready[k]), 32'd0);
      check($sformatf("rst_cpu_err_k%0d", k), 32'(cpu_err[k]), 32'd0);
      check($sformatf("rst_dbg_err_k%0d", k), 32'(dbg_err[k]), 32'd0);
      check($sformatf("rst_cpu_rdata_k%0d", k), 32'(cpu_rdata[k]), 32'd0);
      check($sformatf("rst_dbg_rdata_k%0d", k), 32'(dbg_rdata[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = '1;

    //            k dbg we addr   be     wdata     exp      err
    vecs[0]  = '{0, 1, 1, 8'h02, 2'b11, 16'h000A, 16'h000A, 1'b0};
    vecs[1]  = '{0, 0, 0, 8'h02, 2'b00, 16'h0000, 16'h000A, 1'b0};
    vecs[2]  = '{0, 0, 1, 8'h04, 2'b11, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[3]  = '{0, 0, 1, 8'h04, 2'b01, 16'h1234, 16'hBE34, 1'b0};
    vecs[4]  = '{0, 0, 0, 8'h04, 2'b00, 16'h0000, 16'hBE34, 1'b0};
    vecs[5]  = '{0, 1, 0, 8'h05, 2'b00, 16'h0000, 16'hBE34, 1'b0};
    vecs[6]  = '{0, 1, 1, 8'h06, 2'b11, 16'h5555, 16'h5555, 1'b0};
    vecs[7]  = '{0, 0, 1, 8'h07, 2'b00, 16'hFFFF, 16'h5555, 1'b0};
    vecs[8]  = '{0, 0, 1, 8'h06, 2'b10, 16'hAA00, 16'hAA55, 1'b0};
    vecs[9]  = '{1, 1, 1, 8'h00, 2'b11, 16'h1357, 16'h1357, 1'b0};
    vecs[10] = '{1, 0, 1, 8'h80, 2'b11, 16'hFFFF, 16'h0000, 1'b1};
    vecs[11] = '{1, 0, 0, 8'h00, 2'b00, 16'h0000, 16'h1357, 1'b0};
    vecs[12] = '{1, 1, 1, 8'h7E, 2'b11, 16'h4242, 16'h4242, 1'b0};
    vecs[13] = '{1, 0, 0, 8'h7F, 2'b00, 16'h0000, 16'h4242, 1'b0};
    vecs[14] = '{1, 1, 0, 8'hFE, 2'b00, 16'h0000, 16'h0000, 1'b1};

    for (int i = 0; i < 15; i++) begin
      model_access(vecs[i].k, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, mr, me);
      run_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].dbg, vecs[i].we, vecs[i].addr,
                vecs[i].be, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Both channels request together on instance 0: dbg first, cpu afterwards.
    model_access(0, 1'b0, 8'h04, 2'b00, 16'h0, exp_d, me);
    model_access(0, 1'b0, 8'h02, 2'b00, 16'h0, exp_c, me);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 8'h02; dbg_we = 1'b0; dbg_addr = 8'h04;
    cpu_req[0] = 1'b1; dbg_req[0] = 1'b1;
    @(posedge clk); #1;
    t_d = -1; t_c = -1;
    for (int e = 1; e <= 20 && t_c < 0; e++) begin
      @(posedge clk); #1;
      if (dbg_ready[0] && t_d < 0) begin
        t_d = e;
        check("arb_dbg_rdata", 32'(dbg_rdata[0]), 32'(exp_d));
        check("arb_cpu_hold", 32'(cpu_rdata[0]), 32'(last_cpu[0]));
        dbg_req[0] = 1'b0;
      end
      if (cpu_ready[0] && t_c < 0) begin
        t_c = e;
        check("arb_cpu_rdata", 32'(cpu_rdata[0]), 32'(exp_c));
        check("arb_dbg_hold", 32'(dbg_rdata[0]), 32'(exp_d));
        cpu_req[0] = 1'b0;
      end
    end
    cpu_req[0] = 1'b0; dbg_req[0] = 1'b0;
    check("arb_dbg_edge", 32'(t_d), 32'd3);
    check("arb_cpu_edge", 32'(t_c), 32'd8);
    last_dbg[0] = exp_d; last_cpu[0] = exp_c;
    @(posedge clk); #1;

    // Instance 2 (3 wait states): reset in WAIT aborts a write.
    model_access(2, 1'b1, 8'h10, 2'b11, 16'h1111, mr, me);
    run_check("abort_pre", 2, 1'b1, 1'b1, 8'h10, 2'b11, 16'h1111, 16'h1111, 1'b0);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 8'h10; cpu_be = 2'b11; cpu_wdata = 16'hDEAD; cpu_req[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n[2] = 1'b0; cpu_req[2] = 1'b0;
    #1;
    check("abort_cpu_ready", 32'(cpu_ready[2]), 32'd0);
    check("abort_dbg_ready", 32'(dbg_ready[2]), 32'd0);
    check("abort_cpu_err", 32'(cpu_err[2]), 32'd0);
    check("abort_cpu_rdata", 32'(cpu_rdata[2]), 32'd0);
    check("abort_dbg_rdata", 32'(dbg_rdata[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    last_cpu[2] = '0; last_dbg[2] = '0;
    run_check("abort_read", 2, 1'b0, 1'b0, 8'h10, 2'b00, 16'h0, 16'h1111, 1'b0);

    // Reset while in RESP drops the strobe at once.
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 8'h11; cpu_req[2] = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 20 && !seen; e++) begin
      @(posedge clk); #1;
      if (cpu_ready[2]) seen = 1'b1;
    end
    check("resp_rst_seen", 32'(seen), 32'd1);
    check("resp_rst_data", 32'(cpu_rdata[2]), 32'h1111);
    #2;
    rst_n[2] = 1'b0;
    #1;
    check("resp_rst_ready", 32'(cpu_ready[2]), 32'd0);
    check("resp_rst_rdata", 32'(cpu_rdata[2]), 32'd0);
    cpu_req[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    last_cpu[2] = '0; last_dbg[2] = '0;
    run_check("resp_rst_read", 2, 1'b1, 1'b0, 8'h10, 2'b00, 16'h0, 16'h1111, 1'b0);

    // Instance 1 (no wait states): ramp preload, then 10 back-to-back reads.
    for (int i = 0; i < 10; i++) begin
      model_access(1, 1'b1, 8'(i * 2), 2'b11, 16'(i), mr, me);
      run_check($sformatf("ramp_wr%0d", i), 1, 1'b1, 1'b1, 8'(i * 2), 2'b11, 16'(i), 16'(i), 1'b0);
    end
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_we = 1'b0; cpu_addr = 8'(i * 2); cpu_req[1] = 1'b1;
      seen = 1'b0;
      for (int e = 0; e < 10 && !seen; e++) begin
        @(posedge clk); #1;
        if (cpu_ready[1]) begin
          seen = 1'b1;
          cpu_req[1] = 1'b0;
          check($sformatf("b2b_data%0d", i), 32'(cpu_rdata[1]), 32'(i));
          if (prev >= 0) check($sformatf("b2b_gap%0d", i), 32'(cyc - prev), 32'd3);
          prev = cyc;
        end
      end
      cpu_req[1] = 1'b0;
      check($sformatf("b2b_seen%0d", i), 32'(seen), 32'd1);
    end
    last_cpu[1] = 16'd9;
    @(posedge clk); #1;

    // Randomised traffic against the model on instances 0 and 1.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < depth_of(k); w++) begin
        d = 16'($urandom);
        model_access(k, 1'b1, 8'(w * 2), 2'b11, d, mr, me);
        run_check("preload", k, 1'b1, 1'b1, 8'(w * 2), 2'b11, d, mr, me);
      end
    end
    for (int i = 0; i < 200; i++) begin
      int k;
      bit dbg, we;
      logic [7:0] a;
      logic [1:0] be;
      k   = int'($urandom_range(0, 1));
      dbg = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      be  = 2'($urandom_range(0, 3));
      d   = 16'($urandom);
      model_access(k, we, a, be, d, mr, me);
      run_check($sformatf("rnd%0d", i), k, dbg, we, a, be, d, mr, me);
    end

    check("one_ready_per_cycle", 32'(overlap_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
